// File: rtl/mem_bus_resp.sv
// Memory-bus responder: byte RAM plus an IO window holding
// the UART TX/RX FIFOs, a status register and a program-end register.
module mem_bus_resp #(
  parameter int ADDR_W   = 17,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_overflow,
  output logic        rx_overflow,
  output logic        sim_done,
  output logic [7:0]  sim_code
);

  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = RPW + 1;

  localparam logic [TCW-1:0] TX_FULL = TCW'(TX_DEPTH);
  localparam logic [TCW-1:0] TX_HI   = TCW'(TX_DEPTH - 1);
  localparam logic [RCW-1:0] RX_FULL = RCW'(RX_DEPTH);

  logic [7:0] ram    [2**ADDR_W];
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];

  logic [TPW-1:0] tx_rd, tx_wr;
  logic [TCW-1:0] tx_cnt, tx_cnt_nxt;
  logic [RPW-1:0] rx_rd, rx_wr;
  logic [RCW-1:0] rx_cnt, rx_cnt_nxt;

  logic [ADDR_W-1:0] idx;
  logic is_io, sel_st;
  logic ram_we, sim_we;
  logic tx_push, tx_pop, tx_push_ok, tx_drop;
  logic rx_pop, rx_push_ok, rx_drop, rx_nonempty;
  logic unused_hi;

  assign idx       = mem_a[ADDR_W-1:0];
  assign is_io     = (mem_a[17:16] == 2'b11);
  assign sel_st    = mem_a[2];
  assign unused_hi = ^mem_a[31:18];

  assign tx_valid    = (tx_cnt != '0);
  assign tx_data     = tx_valid ? tx_mem[tx_rd] : 8'h00;
  assign rx_nonempty = (rx_cnt != '0);

  // Access decode and FIFO push/pop qualification.
  always_comb begin
    ram_we     = 1'b0;
    sim_we     = 1'b0;
    tx_push    = 1'b0;
    rx_pop     = 1'b0;
    tx_pop     = tx_valid & tx_ready;
    tx_push_ok = 1'b0;
    tx_drop    = 1'b0;
    rx_push_ok = 1'b0;
    rx_drop    = 1'b0;
    tx_cnt_nxt = tx_cnt;
    rx_cnt_nxt = rx_cnt;
    ram_we  = ~is_io & mem_wr;
    sim_we  = is_io & mem_wr & sel_st;
    tx_push = is_io & mem_wr & ~sel_st;
    rx_pop  = is_io & ~mem_wr & ~sel_st & rx_nonempty;
    // A full TX FIFO still accepts a byte when its head leaves.
    tx_push_ok = tx_push & ((tx_cnt != TX_FULL) | tx_pop);
    tx_drop    = tx_push & ~tx_push_ok;
    rx_push_ok = rx_valid & ((rx_cnt != RX_FULL) | rx_pop);
    rx_drop    = rx_valid & ~rx_push_ok;
    tx_cnt_nxt = tx_cnt + TCW'(tx_push_ok) - TCW'(tx_pop);
    rx_cnt_nxt = rx_cnt + RCW'(rx_push_ok) - RCW'(rx_pop);
  end

  // RAM storage; contents survive reset, writes ignored during reset.
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) ram[idx] <= mem_dout;
  end

  // FIFO storage arrays, written at the current write pointers.
  always_ff @(posedge clk) begin
    if (rst_n && tx_push_ok) tx_mem[tx_wr] <= mem_dout;
    if (rst_n && rx_push_ok) rx_mem[rx_wr] <= rx_data;
  end

  // Registered read data; held across write cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_din <= 8'h00;
    end else if (!mem_wr) begin
      if (!is_io)          mem_din <= ram[idx];
      else if (sel_st)     mem_din <= {6'b0, rx_nonempty, io_buffer_full};
      else if (rx_nonempty) mem_din <= rx_mem[rx_rd];
      else                 mem_din <= 8'h00;
    end
  end

  // TX pointers, count and the early-warning full flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_rd          <= '0;
      tx_wr          <= '0;
      tx_cnt         <= '0;
      io_buffer_full <= 1'b0;
    end else begin
      if (tx_push_ok) tx_wr <= tx_wr + TPW'(1);
      if (tx_pop)     tx_rd <= tx_rd + TPW'(1);
      tx_cnt         <= tx_cnt_nxt;
      io_buffer_full <= (tx_cnt_nxt >= TX_HI);
    end
  end

  // RX pointers and count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_rd  <= '0;
      rx_wr  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push_ok) rx_wr <= rx_wr + RPW'(1);
      if (rx_pop)     rx_rd <= rx_rd + RPW'(1);
      rx_cnt <= rx_cnt_nxt;
    end
  end

  // Sticky overflow flags and the program-end register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_overflow <= 1'b0;
      rx_overflow <= 1'b0;
      sim_done    <= 1'b0;
      sim_code    <= 8'h00;
    end else begin
      if (tx_drop) tx_overflow <= 1'b1;
      if (rx_drop) rx_overflow <= 1'b1;
      if (sim_we) begin
        sim_done <= 1'b1;
        sim_code <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_resp.sv
// Directed bench for mem_bus_resp: RAM, TX/RX FIFOs,
// status, program-end register and reset behaviour.
module tb_mem_bus_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_overflow;
  logic        rx_overflow;
  logic        sim_done;
  logic [7:0]  sim_code;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_RAM  = 32'h0000_1000;
  localparam logic [31:0] A_FIFO = 32'h0003_0000;
  localparam logic [31:0] A_STAT = 32'h0003_0004;

  mem_bus_resp dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .tx_overflow    (tx_overflow),
    .rx_overflow    (rx_overflow),
    .sim_done       (sim_done),
    .sim_code       (sim_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_a    = A_RAM;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    rx_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = 1'b1;
    mem_dout = d;
    tick();
  endtask

  task automatic rd(input logic [31:0] a);
    mem_a  = a;
    mem_wr = 1'b0;
    tick();
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_din",  mem_din, 0);
    check("rst_full", io_buffer_full, 0);
    check("rst_txv",  tx_valid, 0);
    check("rst_txd",  tx_data, 0);
    check("rst_txo",  tx_overflow, 0);
    check("rst_rxo",  rx_overflow, 0);
    check("rst_done", sim_done, 0);
    check("rst_code", sim_code, 0);

    // RAM write then back-to-back reads
    wr(A_RAM + 0, 8'h11);
    wr(A_RAM + 1, 8'h22);
    wr(A_RAM + 2, 8'h33);
    wr(A_RAM + 3, 8'h44);
    rd(A_RAM + 0); check("ram0", mem_din, 8'h11);
    rd(A_RAM + 1); check("ram1", mem_din, 8'h22);
    rd(A_RAM + 2); check("ram2", mem_din, 8'h33);
    rd(A_RAM + 3); check("ram3", mem_din, 8'h44);
    rd(32'h0002_1000); check("alias", mem_din, 8'h11);
    wr(32'h0000_2000, 8'h99);
    check("wr_hold", mem_din, 8'h11);
    rd(32'h0000_2000); check("raw", mem_din, 8'h99);
    rd(32'hFFFC_1001); check("hi_ign", mem_din, 8'h22);

    // TX fill with UART stalled
    for (int i = 1; i <= 6; i++) wr(A_FIFO, 8'h41);
    check("full_6", io_buffer_full, 0);
    wr(A_FIFO, 8'h41);
    check("full_7", io_buffer_full, 1);
    wr(A_FIFO, 8'h41);
    check("ovf_8", tx_overflow, 0);
    wr(A_FIFO, 8'h41);
    check("ovf_9", tx_overflow, 1);
    check("txv_f", tx_valid, 1);

    // TX drain
    idle();
    tx_ready = 1'b1;
    check("drn_d0", tx_data, 8'h41);
    tick();
    check("drn_f7", io_buffer_full, 1);
    tick();
    check("drn_f6", io_buffer_full, 0);
    for (int i = 0; i < 6; i++) begin
      check("drn_d", tx_data, 8'h41);
      tick();
    end
    check("drn_e", tx_valid, 0);
    check("ovf_stk", tx_overflow, 1);

    // TX simultaneous push/pop keeps count and order
    do_reset();
    check("ovf_clr", tx_overflow, 0);
    tx_ready = 1'b0;
    for (int i = 1; i <= 7; i++) wr(A_FIFO, 8'(i));
    tx_ready = 1'b1;
    check("pp_h1", tx_data, 8'h01);
    wr(A_FIFO, 8'h08);
    check("pp_h2", tx_data, 8'h02);
    check("pp_f7", io_buffer_full, 1);
    tx_ready = 1'b0;
    wr(A_FIFO, 8'h09);
    tx_ready = 1'b1;
    wr(A_FIFO, 8'h0A);
    check("pp_novf", tx_overflow, 0);
    idle();
    for (int i = 3; i <= 10; i++) begin
      check("pp_ord", tx_data, i);
      tick();
    end
    check("pp_e", tx_valid, 0);
    check("pp_ovf", tx_overflow, 0);
    tx_ready = 1'b0;

    // RX path and status register
    rx_push(8'h5A);
    rx_push(8'hA5);
    rd(A_STAT); check("st_ne", mem_din, 8'h02);
    rd(A_FIFO); check("rx_0", mem_din, 8'h5A);
    rd(A_FIFO); check("rx_1", mem_din, 8'hA5);
    rd(A_FIFO); check("rx_emp", mem_din, 8'h00);
    rd(A_STAT); check("st_e", mem_din, 8'h00);
    idle();

    // RX overflow keeps the first eight bytes
    for (int i = 0; i < 8; i++) rx_push(8'(8'hB0 + i));
    check("rxo_8", rx_overflow, 0);
    rx_push(8'hB8);
    check("rxo_9", rx_overflow, 1);
    for (int i = 0; i < 8; i++) begin
      rd(A_FIFO);
      check("rxo_d", mem_din, 8'hB0 + i);
    end
    rd(A_STAT); check("rxo_st", mem_din, 8'h00);

    // RX simultaneous pop and push
    idle();
    rx_push(8'hC0);
    rx_valid = 1'b1;
    rx_data  = 8'hC1;
    rd(A_FIFO);
    rx_valid = 1'b0;
    check("rxpp_0", mem_din, 8'hC0);
    rd(A_FIFO); check("rxpp_1", mem_din, 8'hC1);
    rd(A_STAT); check("rxpp_st", mem_din, 8'h00);

    // Status reflects io_buffer_full
    for (int i = 0; i < 7; i++) wr(A_FIFO, 8'h33);
    rd(A_STAT); check("st_full", mem_din, 8'h01);

    // Program-end register
    wr(A_STAT, 8'h07);
    check("done", sim_done, 1);
    check("code", sim_code, 8'h07);
    wr(A_STAT, 8'h09);
    check("code2", sim_code, 8'h09);

    // Reset with TX non-empty; access during reset is ignored
    check("pre_txv", tx_valid, 1);
    rst_n    = 1'b0;
    mem_a    = A_RAM;
    mem_wr   = 1'b1;
    mem_dout = 8'hEE;
    tick();
    rst_n = 1'b1;
    idle();
    check("r2_din",  mem_din, 0);
    check("r2_full", io_buffer_full, 0);
    check("r2_txv",  tx_valid, 0);
    check("r2_txd",  tx_data, 0);
    check("r2_rxo",  rx_overflow, 0);
    check("r2_done", sim_done, 0);
    check("r2_code", sim_code, 0);
    rd(A_RAM); check("r2_ram", mem_din, 8'h11);
    rd(A_STAT); check("r2_st", mem_din, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_resp.md
Name: mem_bus_resp

Overview:
- Responder end of the byte-wide CPU memory bus (`mem_a` / `mem_wr` / `mem_dout` / `mem_din` / `io_buffer_full`) driven by the CPU's memory controller.
- Provides byte RAM with 1-cycle read latency.
- Decodes an IO window at `mem_a[17:16]==2'b11` containing:
  - UART TX FIFO (drives `io_buffer_full`)
  - UART RX FIFO
  - status register
  - simulation-end register
- Sits at the top level between the CPU core and the UART / testbench.

Parameters:
- `ADDR_W`, 17, RAM byte-address width; RAM holds 2^`ADDR_W` bytes.
- `TX_DEPTH`, 8, TX FIFO entries (power of two, ≥4).
- `RX_DEPTH`, 8, RX FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset; single clock domain.
- `mem_a`  in  32  byte address; only [17:0] decoded.
- `mem_wr`  in  1  1 = write this cycle, 0 = read.
- `mem_dout`  in  8  write data from the CPU.
- `mem_din`  out  8  read data, registered.
- `io_buffer_full`  out  1  TX FIFO near-full, registered.
- `tx_valid`  out  1  TX FIFO head valid.
- `tx_data`  out  8  TX FIFO head byte.
- `tx_ready`  in  1  UART accepts head byte.
- `rx_valid`  in  1  incoming UART byte strobe.
- `rx_data`  in  8  incoming UART byte.
- `tx_overflow`  out  1  sticky: a TX write was dropped.
- `rx_overflow`  out  1  sticky: an RX byte was dropped.
- `sim_done`  out  1  sticky: program-end register written.
- `sim_code`  out  8  byte written to the program-end register.

Behaviour:
- Reset (`rst_n`=0 at a clock edge):
  - `mem_din`=0, `io_buffer_full`=0, `tx_valid`=0, `tx_data`=0, `tx_overflow`=0, `rx_overflow`=0, `sim_done`=0, `sim_code`=0.
  - Both FIFO pointers and counts are cleared.
  - RAM contents are not reset.
  - Reset mid-operation discards all FIFO contents; an access in the reset cycle has no effect.
- Address decode uses `mem_a[17:16]`:
  - `2'b11` selects IO; any other value selects RAM at index `mem_a[ADDR_W-1:0]`.
  - With `ADDR_W`=17, `mem_a[17:16]==2'b10` aliases RAM 0x00000–0x0FFFF.
  - Bits [31:18] are ignored.
- Every cycle is an access; there is no idle qualifier. A read of address 0 is harmless.
- RAM write (`mem_wr`=1): `ram[idx]` <= `mem_dout` at the edge.
- RAM read (`mem_wr`=0): `mem_din` <= `ram[idx]` at the edge, i.e. data is valid in the cycle after the address is presented.
  - Back-to-back sequential reads return one byte per cycle.
  - A read from an address written in the previous cycle returns the new value.
- On a write cycle `mem_din` holds its previous value.
- IO registers are selected by `mem_a[2]`; other low bits are ignored.
  - `mem_a[2]`=0, read: `mem_din` <= RX head (0 if RX empty); pop RX if non-empty.
  - `mem_a[2]`=0, write: push `mem_dout` into TX. If TX is full, drop the byte and set `tx_overflow`.
  - `mem_a[2]`=1, read: `mem_din` <= {6'b0, rx_nonempty, `io_buffer_full`}. No side effects.
  - `mem_a[2]`=1, write: `sim_done` <= 1, `sim_code` <= `mem_dout`. Later writes overwrite `sim_code`.
- TX FIFO:
  - `tx_valid` = count != 0.
  - `tx_data` = head entry, combinational from storage.
  - Pop when `tx_valid` && `tx_ready`.
  - Push and pop in the same cycle: count unchanged; push succeeds even when full.
- `io_buffer_full` is registered from the next-state count: 1 when next count ≥ `TX_DEPTH`-1.
  - The one-slot margin exists because the controller samples this flag one cycle before its write lands.
- RX FIFO:
  - Push `rx_data` when `rx_valid`.
  - If RX is full and no pop occurs in the same cycle, drop the byte and set `rx_overflow`.
  - Simultaneous CPU pop and `rx_valid` push: both happen, count unchanged.
- Pointers wrap modulo depth; counts are `log2(depth)+1` bits wide.
- Overflow flags and `sim_done` clear only on reset.

Test Plan:
- RAM path: write 0x11,0x22,0x33,0x44 to 0x01000..0x01003, then read 0x01000..0x01003 on consecutive cycles → `mem_din` = 0x11,0x22,0x33,0x44, each one cycle after its address; read 0x21000 → 0x11 (alias).
- TX flow control: hold `tx_ready`=0, write 0x41 to 0x30000 seven times → `io_buffer_full` rises the cycle after the 7th write.
  - 8th write is accepted; 9th write sets `tx_overflow`.
  - Raise `tx_ready` → bytes 0x41 drain one per cycle and `io_buffer_full` falls once count <7.
- TX simultaneous push/pop with count=7 and `tx_ready`=1 → count stays 7, no overflow, `tx_data` order preserved.
- RX path: pulse `rx_valid` with 0x5A, 0xA5 → status read at 0x30004 returns 0x02; two reads of 0x30000 return 0x5A then 0xA5; a third returns 0x00; status then 0x00.
- RX overflow: push 9 bytes with no reads → `rx_overflow`=1 and the first 8 bytes are retained in order.
- Program end and reset: write 0x07 to 0x30004 → `sim_done`=1, `sim_code`=0x07. Assert `rst_n`=0 for one cycle with TX non-empty → all outputs 0, `tx_valid`=0, RAM byte at 0x01000 still reads 0x11.
